jedro_1_mem_arbiter: RTL and testbench
======================================

# jedro_1_mem_arbiter

Parametrised N-channel memory request arbiter. It merges the core's independent valid/ready request/response ports onto one shared memory port: the instruction port, the data port, and later a debug or DMA port. Arbitration is round-robin with grant locking. An in-order tag FIFO tracks up to MAX_OUTSTANDING accepted requests and routes each response back to the channel that issued it. It sits between jedro_1_top's instr_*/data_* ports and a single-ported memory or bus bridge.

## Interface
- NUM_CH, 2: number of requesting channels (≥1); channel 0 has highest priority out of reset.
- DATA_WIDTH, 32: address and data width.
- MAX_OUTSTANDING, 4: depth of the tag FIFO (≥1; power of two not required).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ch_req_addr_i  in  NUM_CH*DATA_WIDTH  per-channel request address (channel c at slice [c*DATA_WIDTH +: DATA_WIDTH]).
- ch_req_data_i  in  NUM_CH*DATA_WIDTH  per-channel write data.
- ch_req_strobe_i  in  NUM_CH*4  per-channel byte strobes.
- ch_req_write_i  in  NUM_CH  per-channel write flag.
- ch_req_valid_i  in  NUM_CH  per-channel request valid.
- ch_req_ready_o  out  NUM_CH  per-channel request ready; one-hot or zero.
- ch_rsp_data_o  out  NUM_CH*DATA_WIDTH  response data; every slice carries mem_rsp_data_i.
- ch_rsp_err_o  out  NUM_CH  response error; every bit carries mem_rsp_err_i.
- ch_rsp_valid_o  out  NUM_CH  response valid; one-hot or zero.
- ch_rsp_ready_i  in  NUM_CH  per-channel response ready.
- mem_req_addr_o / mem_req_data_o  out  DATA_WIDTH  muxed request address and data.
- mem_req_strobe_o  out  4  muxed strobes.
- mem_req_write_o  out  1  muxed write flag.
- mem_req_valid_o  out  1  muxed request valid.
- mem_req_ready_i  in  1  memory request ready.
- mem_rsp_data_i  in  DATA_WIDTH  memory response data.
- mem_rsp_err_i  in  1  memory response error.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_ready_o  out  1  memory response ready.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current tag FIFO occupancy.

## Operation
- **State**
  - rr_ptr: channel index with highest priority.
  - lock_valid, lock_ch: grant lock.
  - Tag FIFO of MAX_OUTSTANDING entries, each $clog2(NUM_CH) bits (min 1); write pointer, read pointer, occupancy counter.
- **Grant (combinational)**
  - If lock_valid, grant = lock_ch.
  - Otherwise grant = the first channel c with ch_req_valid_i[c], searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - No valid channel means no grant.
- **Request path**
  - mem_req_* muxes the granted channel's fields.
  - mem_req_valid_o = granted channel valid & !full.
  - ch_req_ready_o[grant] = mem_req_ready_i & !full; all other bits are 0.
- **Accept** = mem_req_valid_o & mem_req_ready_i.
  - On accept: push grant into the FIFO, set rr_ptr = (grant+1) mod NUM_CH, clear the lock.
- **Lock**
  - mem_req_valid_o & !mem_req_ready_i sets lock_valid=1, lock_ch=grant. The fields presented to memory therefore stay stable until accepted.
  - Channels must hold valid and fields stable until ready.
- **Full**
  - full = (occupancy == MAX_OUTSTANDING). Full blocks mem_req_valid_o even when a pop occurs in the same cycle (no bypass).
  - While full with a lock held, the lock persists.
- **Response path**
  - head = FIFO read entry.
  - ch_rsp_valid_o[head] = mem_rsp_valid_i & !empty.
  - mem_rsp_ready_o = ch_rsp_ready_i[head] & !empty.
  - Pop on mem_rsp_valid_i & mem_rsp_ready_o.
  - When empty, mem_rsp_ready_o=0 and all ch_rsp_valid_o=0, so a stray response is never consumed.
- **Simultaneous push and pop** (not full): occupancy is unchanged and both pointers advance.
- **Wrap-around**: pointers wrap from MAX_OUTSTANDING-1 to 0 (explicit compare, not a power-of-two mask).
- **Error**: mem_rsp_err_i is passed through unmodified. The arbiter takes no error action and pops normally.

## Timing
- Request and response paths are combinational pass-through: zero added cycles of latency. Throughput is one accept and one response per cycle.
- Arbitration state updates at the edge following an accept or a stall.
- **Reset** (rst_i=1 at an edge):
  - State after reset: rr_ptr=0, lock_valid=0, FIFO empty, outstanding_o=0.
  - Outputs during and after reset: mem_req_valid_o=0 unless a channel is valid; ch_rsp_valid_o=0; mem_rsp_ready_o=0.
  - Reset mid-transaction discards all outstanding tags. Memory must be reset concurrently; responses arriving after reset are not accepted.
- The occupancy counter never exceeds MAX_OUTSTANDING and never underflows. The bench asserts both.

## Test plan
- **Reset then single request**: NUM_CH=2; ch0 read at addr 0x100 with mem ready=1 -> mem_req_addr_o=0x100 in the same cycle, outstanding_o=1; response 0xDEADBEEF -> ch_rsp_valid_o=2'b01 with data 0xDEADBEEF, outstanding_o=0.
- **Round-robin**: ch0 and ch1 both valid every cycle, mem ready=1 -> grants alternate 0,1,0,1; each channel gets 2 of every 4 accepts.
- **Lock under stall**: ch1 granted with mem_req_ready_i=0 for 3 cycles while ch0 asserts valid -> mem_req_addr_o stays at ch1's address; ch1 is accepted first, then ch0.
- **Full**: MAX_OUTSTANDING=4, no responses, 6 requests -> exactly 4 accepted, mem_req_valid_o=0 while full. One response pops an entry -> the next request is accepted the following cycle, not the same cycle.
- **In-order routing with backpressure**: issue ch0, ch1, ch0 requests. The response for ch1 arrives while ch_rsp_ready_i[1]=0 for 2 cycles -> mem_rsp_ready_o=0 for those cycles. Responses reach channels 0, 1, 0 in order; err=1 on the second response appears only on ch_rsp_err_o with ch1 valid.
- **Reset mid-operation**: 3 outstanding, assert rst_i for 1 cycle -> outstanding_o=0, rr_ptr=0. A subsequent mem_rsp_valid_i with an empty FIFO gets mem_rsp_ready_o=0 and all ch_rsp_valid_o=0.

Source files
------------

// File: rtl/jedro_1_mem_arbiter.sv
// N-channel memory request arbiter: round-robin grant with stall locking, plus an
// in-order tag FIFO that steers each memory response back to its issuing channel.
module jedro_1_mem_arbiter #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]           ch_req_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]           ch_req_data_i,
  input  logic [NUM_CH*4-1:0]                    ch_req_strobe_i,
  input  logic [NUM_CH-1:0]                      ch_req_write_i,
  input  logic [NUM_CH-1:0]                      ch_req_valid_i,
  output logic [NUM_CH-1:0]                      ch_req_ready_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]           ch_rsp_data_o,
  output logic [NUM_CH-1:0]                      ch_rsp_err_o,
  output logic [NUM_CH-1:0]                      ch_rsp_valid_o,
  input  logic [NUM_CH-1:0]                      ch_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                  mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]                  mem_req_data_o,
  output logic [3:0]                             mem_req_strobe_o,
  output logic                                   mem_req_write_o,
  output logic                                   mem_req_valid_o,
  input  logic                                   mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rsp_data_i,
  input  logic                                   mem_rsp_err_i,
  input  logic                                   mem_rsp_valid_i,
  output logic                                   mem_rsp_ready_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned TagW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [TagW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  lock_valid_q, lock_valid_d;
  logic [TagW-1:0]       lock_ch_q, lock_ch_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TagW-1:0]       fifo_q [MAX_OUTSTANDING];

  logic [DATA_WIDTH-1:0] addr_arr [NUM_CH];
  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];
  logic [3:0]            strb_arr [NUM_CH];

  logic                  gnt_vld;
  logic [TagW-1:0]       gnt;
  logic [TagW-1:0]       head;
  logic                  full, empty, push, pop;
  int unsigned           idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign addr_arr[c] = ch_req_addr_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign data_arr[c] = ch_req_data_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[c] = ch_req_strobe_i[c*4 +: 4];
  end

  // Locked channel wins; otherwise first valid channel searching from rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (lock_valid_q) begin
      gnt_vld = 1'b1;
      gnt     = lock_ch_q;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!gnt_vld && ch_req_valid_i[TagW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt     = TagW'(idx);
        end
      end
    end
  end

  assign full  = (cnt_q == CntW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  assign mem_req_addr_o   = addr_arr[gnt];
  assign mem_req_data_o   = data_arr[gnt];
  assign mem_req_strobe_o = strb_arr[gnt];
  assign mem_req_write_o  = ch_req_write_i[gnt];
  assign mem_req_valid_o  = gnt_vld && ch_req_valid_i[gnt] && !full;
  assign ch_req_ready_o   = (gnt_vld && mem_req_ready_i && !full) ? (NUM_CH'(1) << gnt) : '0;

  assign ch_rsp_data_o   = {NUM_CH{mem_rsp_data_i}};
  assign ch_rsp_err_o    = {NUM_CH{mem_rsp_err_i}};
  assign ch_rsp_valid_o  = (mem_rsp_valid_i && !empty) ? (NUM_CH'(1) << head) : '0;
  assign mem_rsp_ready_o = !empty && ch_rsp_ready_i[head];

  assign push          = mem_req_valid_o && mem_req_ready_i;
  assign pop           = mem_rsp_valid_i && mem_rsp_ready_o;
  assign outstanding_o = cnt_q;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_ch_d    = lock_ch_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    if (push) begin
      rr_ptr_d     = (gnt == TagW'(NUM_CH - 1)) ? '0 : gnt + TagW'(1);
      lock_valid_d = 1'b0;
      wr_ptr_d     = (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (mem_req_valid_o) begin
      lock_valid_d = 1'b1;
      lock_ch_d    = gnt;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_ch_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_ch_q    <= lock_ch_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Tag storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= gnt;
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Randomized bench for jedro_1_mem_arbiter against a queue-based reference model.
module tb_jedro_1_mem_arbiter;

  localparam int unsigned NCH  = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 3;
  localparam int unsigned CW   = $clog2(MAXO + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH*DW-1:0]  ch_req_addr, ch_req_data, ch_rsp_data;
  logic [NCH*4-1:0]   ch_req_strobe;
  logic [NCH-1:0]     ch_req_write, ch_req_valid, ch_req_ready;
  logic [NCH-1:0]     ch_rsp_err, ch_rsp_valid, ch_rsp_ready;
  logic [DW-1:0]      mem_req_addr, mem_req_data, mem_rsp_data;
  logic [3:0]         mem_req_strobe;
  logic               mem_req_write, mem_req_valid, mem_req_ready;
  logic               mem_rsp_err, mem_rsp_valid, mem_rsp_ready;
  logic [CW-1:0]      outstanding;

  jedro_1_mem_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_req_addr_i(ch_req_addr), .ch_req_data_i(ch_req_data),
    .ch_req_strobe_i(ch_req_strobe), .ch_req_write_i(ch_req_write),
    .ch_req_valid_i(ch_req_valid), .ch_req_ready_o(ch_req_ready),
    .ch_rsp_data_o(ch_rsp_data), .ch_rsp_err_o(ch_rsp_err),
    .ch_rsp_valid_o(ch_rsp_valid), .ch_rsp_ready_i(ch_rsp_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_data_o(mem_req_data),
    .mem_req_strobe_o(mem_req_strobe), .mem_req_write_o(mem_req_write),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_err_i(mem_rsp_err),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
    .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Channel-side pending requests (held stable until handshake).
  logic          v  [NCH];
  logic [DW-1:0] ra [NCH];
  logic [DW-1:0] rd [NCH];
  logic [3:0]    rs [NCH];
  logic          rw [NCH];

  // Reference model: issue-order queue of channel ids, priority start, stalled channel.
  int tags[$];
  int next_pri;
  int locked;

  function automatic int model_grant();
    if (locked >= 0) return locked;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (next_pri + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g, head, rsp_pct;
    bit full, exp_mv, exp_acc, exp_rr, exp_pop;
    logic [NCH-1:0] exp_rdy, exp_rv;

    rst = 1'b1;
    ch_req_addr = '0; ch_req_data = '0; ch_req_strobe = '0; ch_req_write = '0;
    ch_req_valid = '0; ch_rsp_ready = '0; mem_req_ready = 1'b0;
    mem_rsp_data = '0; mem_rsp_err = 1'b0; mem_rsp_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      v[c] = 1'b0; ra[c] = '0; rd[c] = '0; rs[c] = '0; rw[c] = 1'b0;
    end
    tags.delete(); next_pri = 0; locked = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    ch_rsp_ready  = '1;
    #1;
    check_eq("reset_outstanding", 128'(outstanding), 128'(0));
    check_eq("reset_rsp_ready", 128'(mem_rsp_ready), 128'(0));
    check_eq("reset_rsp_valid", 128'(ch_rsp_valid), 128'(0));
    check_eq("reset_req_valid", 128'(mem_req_valid), 128'(0));
    @(negedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      case ((cyc / 250) % 4)
        0: rsp_pct = 0;
        1: rsp_pct = 15;
        2: rsp_pct = 50;
        default: rsp_pct = 90;
      endcase
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (!v[c] && $urandom_range(0, 99) < 60) begin
          v[c] = 1'b1; ra[c] = $urandom; rd[c] = $urandom;
          rs[c] = 4'($urandom); rw[c] = 1'($urandom);
        end
        ch_req_valid[c]         = v[c];
        ch_req_addr[c*DW +: DW] = ra[c];
        ch_req_data[c*DW +: DW] = rd[c];
        ch_req_strobe[c*4 +: 4] = rs[c];
        ch_req_write[c]         = rw[c];
      end
      mem_req_ready = ($urandom_range(0, 99) < 65);
      mem_rsp_valid = ($urandom_range(0, 99) < rsp_pct);
      mem_rsp_data  = $urandom;
      mem_rsp_err   = 1'($urandom);
      ch_rsp_ready  = NCH'($urandom);
      #1;

      g       = model_grant();
      full    = (tags.size() == MAXO);
      exp_mv  = (g >= 0) && v[g] && !full;
      exp_acc = exp_mv && mem_req_ready;
      exp_rdy = ((g >= 0) && mem_req_ready && !full) ? NCH'(1 << g) : '0;
      if (tags.size() > 0) begin
        head    = tags[0];
        exp_rv  = mem_rsp_valid ? NCH'(1 << head) : '0;
        exp_rr  = ch_rsp_ready[head];
      end else begin
        head    = -1;
        exp_rv  = '0;
        exp_rr  = 1'b0;
      end
      exp_pop = mem_rsp_valid && exp_rr;

      check_eq("req_valid", 128'(mem_req_valid), 128'(exp_mv));
      check_eq("req_ready", 128'(ch_req_ready), 128'(exp_rdy));
      if (exp_mv) begin
        check_eq("req_addr", 128'(mem_req_addr), 128'(ra[g]));
        check_eq("req_data", 128'(mem_req_data), 128'(rd[g]));
        check_eq("req_strobe", 128'(mem_req_strobe), 128'(rs[g]));
        check_eq("req_write", 128'(mem_req_write), 128'(rw[g]));
      end
      check_eq("rsp_valid", 128'(ch_rsp_valid), 128'(exp_rv));
      check_eq("rsp_ready", 128'(mem_rsp_ready), 128'(exp_rr));
      check_eq("rsp_data", 128'(ch_rsp_data), 128'({NCH{mem_rsp_data}}));
      check_eq("rsp_err", 128'(ch_rsp_err), 128'({NCH{mem_rsp_err}}));
      check_eq("outstanding", 128'(outstanding), 128'(tags.size()));
      check_eq("occ_bound", 128'(outstanding <= CW'(MAXO)), 128'(1));

      if (exp_acc) v[g] = 1'b0;
      if (rst) begin
        tags.delete(); next_pri = 0; locked = -1;
      end else begin
        if (exp_pop) void'(tags.pop_front());
        if (exp_acc) begin
          tags.push_back(g);
          next_pri = (g + 1) % NCH;
          locked   = -1;
        end else if (exp_mv) begin
          locked = g;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
